// File: rtl/dmem_lsu.sv
// Byte-writable data memory with RV32I load/store formatting for the memory stage.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses report o_err instead of splitting.
module dmem_lsu #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BA_W  = IDX_W + 2;

  // Handshake: a request is taken on a rising edge where i_req && o_ready;
  // o_ready stays low until the single-cycle o_rvalid completion pulse has passed,
  // and requests presented while o_ready is low are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [BA_W-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_word;
  logic [31:0]      lo_q;
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       off;
  logic [3:0]       size_msk;
  logic [7:0]       be8;
  logic [63:0]      wdata64;
  logic [63:0]      rword64;
  logic [31:0]      shifted;
  logic [31:0]      fmt;
  logic [31:0]      resp_data;
  logic             legal;
  logic             mis;
  logic             trap;
  logic             err_c;
  logic             wr_lo;
  logic             wr_hi;

  if (ADDR_W > BA_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[ADDR_W-1:BA_W];
  end

  assign idx_lo = addr_q[BA_W-1:2];
  assign idx_hi = idx_lo + IDX_W'(1);
  assign off    = addr_q[1:0];

  always_comb begin
    size_msk = 4'b0001;
    case (f3_q[1:0])
      2'b01:          size_msk = 4'b0011;
      2'b10, 2'b11:   size_msk = 4'b1111;
      default:        size_msk = 4'b0001;
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we_q;
      default:                legal = 1'b0;
    endcase
  end

  // Lane enables and data over a two-word window; the upper half targets word+1.
  assign be8     = {4'b0000, size_msk} << off;
  assign wdata64 = {32'b0, wdata_q} << {off, 3'b000};
  assign mis     = |be8[7:4];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = mis;
`else
  assign trap = 1'b0;
`endif

  assign err_c  = !legal || trap;
  assign wr_lo  = (state == ACC0) && we_q && !err_c;
  assign wr_hi  = (state == ACC1) && we_q;
  assign rd_idx = (state == ACC1) ? idx_hi : idx_lo;

  always_ff @(posedge i_clk) begin
    if (wr_lo) begin
      for (int b = 0; b < 4; b++) begin
        if (be8[b]) mem[idx_lo][8*b +: 8] <= wdata64[8*b +: 8];
      end
    end
    if (wr_hi) begin
      for (int b = 0; b < 4; b++) begin
        if (be8[b+4]) mem[idx_hi][8*b +: 8] <= wdata64[32+8*b +: 8];
      end
    end
    rd_word <= mem[rd_idx];
    if (state == ACC1) lo_q <= rd_word;
  end

  // Misaligned loads: lo_q holds the low word, rd_word the word above it.
  assign rword64 = mis ? {rd_word, lo_q} : {32'b0, rd_word};
  assign shifted = 32'(rword64 >> {off, 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  fmt = {24'b0, shifted[7:0]};
      3'b101:  fmt = {16'b0, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  assign resp_data = (we_q || err_c) ? 32'b0 : fmt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_req) begin
        we_q    <= i_we;
        f3_q    <= i_funct3;
        addr_q  <= i_addr[BA_W-1:0];
        wdata_q <= i_wdata;
      end
      if (state == RESP) rdata_q <= resp_data;
    end
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_rvalid = 1'b0;
    o_err    = 1'b0;
    o_rdata  = rdata_q;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req) state_nx = ACC0;
      end
      ACC0: state_nx = (!err_c && mis) ? ACC1 : RESP;
      ACC1: state_nx = RESP;
      RESP: begin
        o_rvalid = 1'b1;
        o_err    = err_c;
        o_rdata  = resp_data;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-addressed reference memory, expected-result queue, directed and random accesses.
`timescale 1ns/1ps
module tb_dmem_lsu;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int NB     = DEPTH * 4;
  localparam int BW     = $clog2(DEPTH) + 2;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  logic [7:0]  ref_mem [NB];
  logic [36:0] exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] last_data;
  logic        last_err;

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_req(req), .i_we(we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic m_we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] data,
                                output logic e, output int lat);
    int n;
    int base;
    int off;
    logic legal;
    logic mis;
    logic [31:0] v;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    case (f3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !m_we;
      default:          legal = 1'b0;
    endcase
    base = int'(a[BW-1:0]);
    off  = int'(a[1:0]);
    mis  = (off + n) > 4;
    data = 32'b0;
    e    = 1'b0;
    lat  = 2;
    if (!legal) e = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    else if (mis) e = 1'b1;
`endif
    else begin
      if (mis) lat = 3;
      if (m_we) begin
        for (int i = 0; i < n; i++) ref_mem[(base + i) % NB] = wd[8*i +: 8];
      end else begin
        v = 32'b0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(base + i) % NB];
        if (n == 1)      data = f3[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        else if (n == 2) data = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else             data = v;
      end
    end
  endfunction

  // Drives one request; when noisy, keeps a bogus store request up while the DUT is busy.
  task automatic access(input logic a_we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit noisy);
    logic [31:0] e_data;
    logic        e_err;
    int          e_lat;
    logic [36:0] e;
    int          cyc;
    model(a_we, f3, a, wd, e_data, e_err, e_lat);
    exp_q.push_back({4'(e_lat), e_err, e_data});
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_idle: ready=%b required 1", ready);
    end
    req = 1'b1; we = a_we; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = noisy; we = 1'b1; funct3 = 3'b010; addr = $urandom; wdata = $urandom;
    cyc = 1;
    checks++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy: ready=%b required 0", ready);
    end
    while (rvalid !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1) begin
      fails++;
      $display("FAIL rvalid_timeout: no rvalid within %0d cycles, addr=%h", cyc, a);
    end else begin
      checks++;
      if (cyc != int'(e[36:33])) begin
        fails++;
        $display("FAIL latency: got %0d required %0d (addr=%h f3=%0d we=%b)", cyc, e[36:33], a, f3, a_we);
      end
      checks++;
      if (err !== e[32]) begin
        fails++;
        $display("FAIL err: got %b required %b (addr=%h f3=%0d we=%b)", err, e[32], a, f3, a_we);
      end
      checks++;
      if (rdata !== e[31:0]) begin
        fails++;
        $display("FAIL rdata: got %h required %h (addr=%h f3=%0d we=%b)", rdata, e[31:0], a, f3, a_we);
      end
      last_data = rdata;
      last_err  = err;
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b0) begin
        fails++;
        $display("FAIL rvalid_pulse: rvalid=%b required 0 after one cycle", rvalid);
      end
      checks++;
      if (rdata !== e[31:0]) begin
        fails++;
        $display("FAIL rdata_hold: got %h required %h", rdata, e[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", ready); end
    checks++;
    if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b required 0", rvalid); end
    checks++;
    if (rdata !== 32'b0) begin fails++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) access(1'b1, 3'b010, 32'(i * 4), 32'hC0DE0000 | 32'(i), 1'b0);
  endtask

  task automatic test_word_and_subword();
    logic [31:0] want [6];
    logic [2:0]  f3s  [6];
    logic [31:0] adrs [6];
    want = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEAD55EF};
    f3s  = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    adrs = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    checks++;
    if (last_err !== 1'b0) begin fails++; $display("FAIL sw_err: got %b required 0", last_err); end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) access(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 1'b0);
      access(1'b0, f3s[i], adrs[i], 32'b0, 1'b0);
      checks++;
      if (last_data !== want[i]) begin
        fails++;
        $display("FAIL subword_%0d: got %h required %h", i, last_data, want[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] w3, w4, w_mid;
`ifdef DMEM_MISALIGN_TRAP_EN
    w3 = 32'hC0DE0003; w4 = 32'hDEAD55EF; w_mid = 32'h0;
`else
    w3 = 32'h33440003; w4 = 32'hDEAD1122; w_mid = 32'h11223344;
`endif
    access(1'b1, 3'b010, 32'h0E, 32'h11223344, 1'b0);
    access(1'b0, 3'b010, 32'h0C, 32'b0, 1'b0);
    checks++;
    if (last_data !== w3) begin fails++; $display("FAIL mis_low_word: got %h required %h", last_data, w3); end
    access(1'b0, 3'b010, 32'h0E, 32'b0, 1'b0);
    checks++;
    if (last_data !== w_mid) begin fails++; $display("FAIL mis_lw: got %h required %h", last_data, w_mid); end
    access(1'b0, 3'b010, 32'h10, 32'b0, 1'b0);
    checks++;
    if (last_data !== w4) begin fails++; $display("FAIL mis_high_word: got %h required %h", last_data, w4); end
  endtask

  task automatic test_wrap();
    logic [31:0] top, bot;
`ifdef DMEM_MISALIGN_TRAP_EN
    top = 32'hC0DE000F; bot = 32'hC0DE0000;
`else
    top = 32'hC3D4000F; bot = 32'hC0DEA1B2;
`endif
    access(1'b1, 3'b010, 32'(NB - 2), 32'hA1B2C3D4, 1'b0);
    access(1'b0, 3'b010, 32'hFFFF_FF00 | 32'(NB - 4), 32'b0, 1'b0);
    checks++;
    if (last_data !== top) begin fails++; $display("FAIL wrap_top: got %h required %h", last_data, top); end
    access(1'b0, 3'b010, 32'h0000_0100, 32'b0, 1'b0);
    checks++;
    if (last_data !== bot) begin fails++; $display("FAIL wrap_word0: got %h required %h", last_data, bot); end
  endtask

  task automatic test_illegal();
    access(1'b0, 3'b011, 32'h10, 32'b0, 1'b0);
    checks++;
    if (last_err !== 1'b1 || last_data !== 32'b0) begin
      fails++;
      $display("FAIL illegal_load: err=%b data=%h required err=1 data=0", last_err, last_data);
    end
    access(1'b1, 3'b101, 32'h20, 32'hFFFFFFFF, 1'b0);
    access(1'b1, 3'b111, 32'h20, 32'hFFFFFFFF, 1'b0);
    access(1'b0, 3'b010, 32'h20, 32'b0, 1'b0);
    checks++;
    if (last_data !== 32'hC0DE0008) begin
      fails++;
      $display("FAIL illegal_store_nowrite: got %h required c0de0008", last_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w7;
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h1E; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    w7 = 32'hC0DE0007;
`else
    w7 = 32'hF00D0007;
    ref_mem[8'h1E] = 8'h0D;
    ref_mem[8'h1F] = 8'hF0;
`endif
    #1;
    checks++;
    if (rvalid !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_now: rvalid=%b ready=%b required 0/1", rvalid, ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b0 || ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_after_%0d: rvalid=%b ready=%b required 0/1", i, rvalid, ready);
      end
    end
    access(1'b0, 3'b010, 32'h20, 32'b0, 1'b0);
    checks++;
    if (last_data !== 32'hC0DE0008) begin fails++; $display("FAIL reset_mid_high: got %h required c0de0008", last_data); end
    access(1'b0, 3'b010, 32'h1C, 32'b0, 1'b0);
    checks++;
    if (last_data !== w7) begin fails++; $display("FAIL reset_mid_low: got %h required %h", last_data, w7); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 250; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH; i++) access(1'b0, 3'b010, 32'(i * 4), 32'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_word_and_subword();
    test_misaligned();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
